// File: rtl/cache_sim_pkg.sv
// cache_sim_pkg: shared trace sequencer states and trace ROM constants
package cache_sim_pkg;
  localparam int TRACE_ADDR_W = 16;
  localparam int TRACE_DATA_W = 32;
  localparam logic [TRACE_DATA_W-1:0] TRACE_SENTINEL = 32'h0000FFFF;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_RESP, DONE} seq_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (clr) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/trace_sequencer.sv
// trace_sequencer: replays a trace ROM into the cache one reference at a time and tallies results
module trace_sequencer
  import cache_sim_pkg::*;
#(
  parameter int                       CNT_W     = 16,
  parameter logic [TRACE_DATA_W-1:0] SENTINEL  = TRACE_SENTINEL,
  parameter logic [TRACE_ADDR_W-1:0] LAST_ADDR = 16'hFFFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [TRACE_ADDR_W-1:0] trace_addr,
  input  logic [TRACE_DATA_W-1:0] trace_ref,
  output logic                    ref_valid,
  output logic [TRACE_DATA_W-1:0] ref_data,
  input  logic                    ref_ready,
  input  logic                    resp_valid,
  input  logic                    resp_hit,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        ref_count,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);
  seq_state_t st, nxt;
  logic clr, acc, rsp, fin;
  always_comb begin
    clr = (st == IDLE || st == DONE) && start;
    acc = st == ISSUE && ref_ready;
    rsp = st == WAIT_RESP && resp_valid;
    fin = st == FETCH && trace_ref == SENTINEL;
    nxt = clr ? FETCH :
          fin ? DONE :
          st == FETCH ? ISSUE :
          acc ? WAIT_RESP :
          rsp ? (trace_addr == LAST_ADDR ? DONE : FETCH) : st;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      trace_addr <= '0;
      ref_data <= '0;
      ref_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= nxt;
      busy <= nxt inside {FETCH, ISSUE, WAIT_RESP};
      done <= nxt == DONE;
      trace_addr <= clr ? '0 : (rsp && trace_addr != LAST_ADDR) ? trace_addr + 1'b1 : trace_addr;
      ref_valid <= (st == FETCH && !fin) || (st == ISSUE && !ref_ready);
      if (st == FETCH && !fin) ref_data <= trace_ref;
    end
  sat_counter #(.W(CNT_W)) u_ref (.clk(clk), .rst(rst), .clr(clr), .inc(acc), .q(ref_count));
  sat_counter #(.W(CNT_W)) u_hit (.clk(clk), .rst(rst), .clr(clr), .inc(rsp && resp_hit), .q(hit_count));
  sat_counter #(.W(CNT_W)) u_miss (.clk(clk), .rst(rst), .clr(clr), .inc(rsp && !resp_hit), .q(miss_count));
endmodule

// File: tb/tb_trace_sequencer.sv
// tb_trace_sequencer: randomized replay of stored traces against a reference-level model
module tb_trace_sequencer;
  localparam logic [31:0] SENT = 32'h0000FFFF;
  localparam int M_IDLE = 0, M_FETCH = 1, M_ISSUE = 2, M_WAIT = 3, M_DONE = 4;
  logic clk = 1'b0;
  logic rst, start, ref_ready, resp_valid, resp_hit;
  logic [15:0] ta, ta4;
  logic [31:0] tr, tr4, rd, rd4;
  logic rv, rv4, busy, busy4, done, done4;
  logic [15:0] rc, hc, mc;
  logic [3:0] rc4, hc4, mc4;
  logic [31:0] rom_mem [64];
  int rom_len;
  bit rand_rdy, rand_dly, noise, stall_en;
  int hit_mode;
  bit pend, alt, stall_armed;
  int dly, stall_left, stall_seen;
  int ph, k, nref, nhit, nmiss;
  logic [31:0] eref;
  int nerr = 0, nchk = 0;
  always #5 clk = ~clk;
  trace_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .trace_addr(ta), .trace_ref(tr),
    .ref_valid(rv), .ref_data(rd), .ref_ready(ref_ready), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .busy(busy), .done(done), .ref_count(rc), .hit_count(hc),
    .miss_count(mc)
  );
  trace_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .trace_addr(ta4), .trace_ref(tr4),
    .ref_valid(rv4), .ref_data(rd4), .ref_ready(ref_ready), .resp_valid(resp_valid),
    .resp_hit(resp_hit), .busy(busy4), .done(done4), .ref_count(rc4), .hit_count(hc4),
    .miss_count(mc4)
  );
  always_comb tr = (int'(ta) < rom_len) ? rom_mem[ta[5:0]] : SENT;
  always_comb tr4 = (int'(ta4) < rom_len) ? rom_mem[ta4[5:0]] : SENT;
  function automatic logic [31:0] rom(input int a);
    return (a < rom_len) ? rom_mem[a] : SENT;
  endfunction
  function automatic int sat(input int n, input int mx);
    return n > mx ? mx : n;
  endfunction
  // reference model: where in the trace we are and what totals the cache has reported
  always @(posedge clk or posedge rst)
    if (rst) begin
      ph <= M_IDLE;
      k <= 0;
      eref <= '0;
      nref <= 0;
      nhit <= 0;
      nmiss <= 0;
    end else if ((ph == M_IDLE || ph == M_DONE) && start) begin
      ph <= M_FETCH;
      k <= 0;
      nref <= 0;
      nhit <= 0;
      nmiss <= 0;
    end else if (ph == M_FETCH) begin
      if (rom(k) == SENT) ph <= M_DONE;
      else begin
        ph <= M_ISSUE;
        eref <= rom(k);
      end
    end else if (ph == M_ISSUE && ref_ready) begin
      nref <= nref + 1;
      ph <= M_WAIT;
    end else if (ph == M_WAIT && resp_valid) begin
      if (resp_hit) nhit <= nhit + 1;
      else nmiss <= nmiss + 1;
      if (k == 65535) ph <= M_DONE;
      else begin
        k <= k + 1;
        ph <= M_FETCH;
      end
    end
  // cache stand-in: ready policy, response delay, hit pattern, stray response pulses
  always @(negedge clk) begin
    if (!stall_en) begin
      stall_armed = 1'b1;
      stall_seen = 0;
      stall_left = 0;
    end
    if (!busy) alt = 1'b1;
    if (rst) begin
      pend = 1'b0;
      ref_ready = 1'b0;
      resp_valid = 1'b0;
      resp_hit = 1'b0;
    end else begin
      resp_valid = 1'b0;
      resp_hit = 1'($urandom % 2);
      if (pend) begin
        if (dly == 0) begin
          resp_valid = 1'b1;
          resp_hit = hit_mode == 0 ? alt : hit_mode == 1 ? 1'b1 : 1'($urandom % 2);
          alt = !alt;
          pend = 1'b0;
        end else dly--;
      end else if (noise) resp_valid = 1'($urandom % 2);
      if (rv) begin
        if (stall_en && stall_armed && rd == 32'h0000000A) begin
          stall_left = 5;
          stall_armed = 1'b0;
        end
        if (stall_en && rd == 32'h0000000A) stall_seen++;
        ref_ready = stall_left > 0 ? 1'b0 : rand_rdy ? 1'($urandom % 2) : 1'b1;
        if (stall_left > 0) stall_left--;
        if (ref_ready) begin
          pend = 1'b1;
          dly = rand_dly ? $urandom_range(0, 3) : 0;
        end
      end else ref_ready = rand_rdy ? 1'($urandom % 2) : 1'b1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    if (!rst) begin
      chk("addr", 32'(ta), 32'(k));
      chk("valid", 32'(rv), 32'(ph == M_ISSUE));
      chk("data", rd, eref);
      chk("busy", 32'(busy), 32'(ph >= M_FETCH && ph <= M_WAIT));
      chk("done", 32'(done), 32'(ph == M_DONE));
      chk("refs", 32'(rc), sat(nref, 65535));
      chk("hits", 32'(hc), sat(nhit, 65535));
      chk("misses", 32'(mc), sat(nmiss, 65535));
      chk("addr4", 32'(ta4), 32'(k));
      chk("valid4", 32'(rv4), 32'(ph == M_ISSUE));
      chk("data4", rd4, eref);
      chk("busy4", 32'(busy4), 32'(ph >= M_FETCH && ph <= M_WAIT));
      chk("done4", 32'(done4), 32'(ph == M_DONE));
      chk("refs4", 32'(rc4), sat(nref, 15));
      chk("hits4", 32'(hc4), sat(nhit, 15));
      chk("misses4", 32'(mc4), sat(nmiss, 15));
    end
  endtask
  task automatic zero_check(input string tag);
    chk({tag, "_addr"}, 32'(ta) | 32'(ta4), 0);
    chk({tag, "_data"}, rd | rd4, 0);
    chk({tag, "_valid"}, 32'(rv | rv4), 0);
    chk({tag, "_busy"}, 32'(busy | busy4), 0);
    chk({tag, "_done"}, 32'(done | done4), 0);
    chk({tag, "_cnt"}, 32'(rc | hc | mc), 0);
    chk({tag, "_cnt4"}, 32'(rc4 | hc4 | mc4), 0);
  endtask
  task automatic set_rom(input int mode);
    rom_len = mode == 0 ? 19 : mode == 1 ? 0 : mode == 2 ? 20 : $urandom_range(0, 24);
    for (int i = 0; i < 64; i++) begin
      rom_mem[i] = mode == 0 ? 32'(i + 1) : mode == 2 ? 32'hC0DE0000 + 32'(i) : $urandom;
      if (rom_mem[i] == SENT) rom_mem[i] = 32'h00010000;
    end
  endtask
  task automatic start_and_check(input string tag);
    logic [31:0] r0;
    r0 = rom(0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({tag, "_lat1_busy"}, 32'(busy), 1);
    chk({tag, "_lat1_done"}, 32'(done), 0);
    chk({tag, "_lat1_valid"}, 32'(rv), 0);
    chk({tag, "_lat1_refs"}, 32'(rc), 0);
    tick;
    chk({tag, "_lat2_valid"}, 32'(rv), 32'(r0 != SENT));
    chk({tag, "_lat2_done"}, 32'(done), 32'(r0 == SENT));
    if (r0 != SENT) chk({tag, "_first_ref"}, rd, r0);
  endtask
  task automatic run_wait(input string tag, input int budget, input bit pulse, output int n);
    n = 0;
    while (!done && n < budget) begin
      start = pulse && busy && ($urandom % 6 == 0);
      tick;
      n++;
    end
    start = 1'b0;
    chk({tag, "_finished"}, 32'(done), 1);
  endtask
  task automatic expect_totals(input string tag, input int r, input int h, input int m);
    chk({tag, "_refs"}, 32'(rc), r);
    chk({tag, "_hits"}, 32'(hc), h);
    chk({tag, "_misses"}, 32'(mc), m);
    chk({tag, "_addr"}, 32'(ta), 32'h13);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask
  initial begin
    int n;
    rst = 1'b1;
    start = 1'b0;
    rand_rdy = 0;
    rand_dly = 0;
    noise = 0;
    stall_en = 0;
    hit_mode = 0;
    set_rom(0);
    tick;
    zero_check("reset");
    tick;
    rst = 1'b0;
    tick;
    start_and_check("trace");
    run_wait("trace", 400, 0, n);
    chk("trace_cycles", 32'(n + 2), 59);
    expect_totals("trace", 19, 10, 9);
    stall_en = 1;
    start_and_check("stall");
    run_wait("stall", 400, 0, n);
    chk("stall_hold_cycles", 32'(stall_seen), 6);
    expect_totals("stall", 19, 10, 9);
    stall_en = 0;
    noise = 1;
    start_and_check("noise");
    run_wait("noise", 400, 1, n);
    expect_totals("noise", 19, 10, 9);
    noise = 0;
    start_and_check("areset");
    n = 0;
    while (!(busy && !rv && 32'(rc) == 32'(hc) + 32'(mc) + 1 && rc >= 3) && n < 300) begin
      tick;
      n++;
    end
    chk("areset_reached_wait", 32'(n < 300), 1);
    #2 rst = 1'b1;
    #1 zero_check("areset");
    tick;
    #2 rst = 1'b0;
    tick;
    start_and_check("replay");
    chk("replay_addr", 32'(ta), 0);
    run_wait("replay", 400, 0, n);
    expect_totals("replay", 19, 10, 9);
    set_rom(1);
    start_and_check("empty");
    chk("empty_cnt", 32'(rc | hc | mc), 0);
    chk("empty_addr", 32'(ta), 0);
    set_rom(2);
    hit_mode = 1;
    rand_rdy = 1;
    rand_dly = 1;
    start_and_check("sat");
    run_wait("sat", 1000, 1, n);
    chk("sat_refs4", 32'(rc4), 15);
    chk("sat_hits4", 32'(hc4), 15);
    chk("sat_misses4", 32'(mc4), 0);
    chk("sat_refs16", 32'(rc), 20);
    chk("sat_addr", 32'(ta), 20);
    for (int r = 0; r < 8; r++) begin
      set_rom(3);
      hit_mode = $urandom_range(0, 2);
      rand_rdy = 1'($urandom % 2);
      rand_dly = 1'($urandom % 2);
      noise = 1'($urandom % 2);
      start_and_check("rand");
      run_wait("rand", 2000, 1, n);
      chk("rand_refs", 32'(rc), rom_len);
      repeat ($urandom_range(0, 3)) tick;
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
